// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the RS issue scheduler: FU class codes, MEM handshake states
// and the per-FU readiness bit layout.
package rs_issue_scheduler_pkg;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MEM = 2'd1;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_PEND = 1'b1
    } mem_fsm_state_e;

    // Bit order {mem, alu2, alu1}; 1 = unit can accept an op this cycle
    typedef struct packed {
        logic mem;
        logic alu2;
        logic alu1;
    } fu_rdy_t;

endpackage

// File: rtl/rs_issue_scheduler_age_picker.sv
// Combinational oldest / second-oldest selector over a request mask.
// Smaller age is older; on equal age the lower index wins.
module issue_age_picker #(
    parameter int RS_SIZE  = 16,
    parameter int AGE_W    = 4,
    localparam int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0]       req,
    input  logic [AGE_W*RS_SIZE-1:0] ages,
    output logic                     first_valid,
    output logic [IDX_W-1:0]         first_idx,
    output logic                     second_valid,
    output logic [IDX_W-1:0]         second_idx
);

    logic [AGE_W-1:0] first_age;
    logic [AGE_W-1:0] second_age;

    // Strict '<' while scanning upward keeps the lower index on ties
    always_comb begin
        first_valid = 1'b0;
        first_idx   = '0;
        first_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (req[i] && (!first_valid || ages[i*AGE_W +: AGE_W] < first_age)) begin
                first_valid = 1'b1;
                first_idx   = IDX_W'(i);
                first_age   = ages[i*AGE_W +: AGE_W];
            end
        end
    end

    always_comb begin
        second_valid = 1'b0;
        second_idx   = '0;
        second_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (req[i] && !(first_valid && first_idx == IDX_W'(i)) &&
                (!second_valid || ages[i*AGE_W +: AGE_W] < second_age)) begin
                second_valid = 1'b1;
                second_idx   = IDX_W'(i);
                second_age   = ages[i*AGE_W +: AGE_W];
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue scheduler: up to two ALU ops and one MEM op per cycle, oldest first by ROB age.
// Optional perf counters are built only when ISSUE_PERF_CNT_EN is defined.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int RS_SIZE  = 16,
    parameter int ROB_BITS = 4,
    localparam int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [RS_SIZE-1:0]          rs_ready,
    input  logic [2*RS_SIZE-1:0]        rs_fu,
    input  logic [ROB_BITS*RS_SIZE-1:0] rs_rob,
    input  logic [ROB_BITS-1:0]         rob_head,
    input  logic                        mem_ready,
    output logic                        alu1_valid,
    output logic [IDX_W-1:0]            alu1_idx,
    output logic                        alu2_valid,
    output logic [IDX_W-1:0]            alu2_idx,
    output logic                        mem_valid,
    output logic [IDX_W-1:0]            mem_idx,
    output logic [RS_SIZE-1:0]          grant_mask,
    output logic [2:0]                  fu_rdy,
    output logic [31:0]                 perf_alu_issue,
    output logic [31:0]                 perf_mem_stall
);

    logic [RS_SIZE-1:0]          cand;
    logic [RS_SIZE-1:0]          alu_req;
    logic [RS_SIZE-1:0]          mem_req;
    logic [ROB_BITS*RS_SIZE-1:0] ages;
    logic                        alu_first_v, alu_second_v, mem_first_v;
    logic [IDX_W-1:0]            alu_first_idx, alu_second_idx, mem_first_idx;
    logic                        mem_second_v_unused;
    logic [IDX_W-1:0]            mem_second_idx_unused;
    logic                        mem_issue;
    logic [RS_SIZE-1:0]          grant_next;
    mem_fsm_state_e              state, state_next;
    fu_rdy_t                     rdy;

    // Entries granted last edge are still visible on rs_ready; mask them out
    assign cand = rs_ready & ~grant_mask;

    always_comb begin
        alu_req = '0;
        mem_req = '0;
        ages    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            alu_req[i] = cand[i] && (rs_fu[2*i +: 2] == FU_ALU);
            mem_req[i] = cand[i] && (rs_fu[2*i +: 2] == FU_MEM);
            ages[i*ROB_BITS +: ROB_BITS] = rs_rob[i*ROB_BITS +: ROB_BITS] - rob_head;
        end
    end

    issue_age_picker #(.RS_SIZE(RS_SIZE), .AGE_W(ROB_BITS)) u_alu_pick (
        .req          (alu_req),
        .ages         (ages),
        .first_valid  (alu_first_v),
        .first_idx    (alu_first_idx),
        .second_valid (alu_second_v),
        .second_idx   (alu_second_idx)
    );

    issue_age_picker #(.RS_SIZE(RS_SIZE), .AGE_W(ROB_BITS)) u_mem_pick (
        .req          (mem_req),
        .ages         (ages),
        .first_valid  (mem_first_v),
        .first_idx    (mem_first_idx),
        .second_valid (mem_second_v_unused),
        .second_idx   (mem_second_idx_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= MEM_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (mem_first_v) state_next = MEM_PEND;
            MEM_PEND: if (mem_ready)   state_next = MEM_IDLE;
            default:                   state_next = MEM_IDLE;
        endcase
        if (flush) state_next = MEM_IDLE;
    end

    always_comb begin
        mem_issue = (state == MEM_IDLE) && mem_first_v && !flush;
        mem_valid = (state == MEM_PEND);
        rdy.alu1  = 1'b1;
        rdy.alu2  = 1'b1;
        rdy.mem   = (state == MEM_IDLE);
    end

    assign fu_rdy = rdy;

    always_comb begin
        grant_next = '0;
        if (alu_first_v)  grant_next[alu_first_idx]  = 1'b1;
        if (alu_second_v) grant_next[alu_second_idx] = 1'b1;
        if (mem_issue)    grant_next[mem_first_idx]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu1_valid <= 1'b0;
            alu1_idx   <= '0;
            alu2_valid <= 1'b0;
            alu2_idx   <= '0;
            mem_idx    <= '0;
            grant_mask <= '0;
        end else if (flush) begin
            alu1_valid <= 1'b0;
            alu2_valid <= 1'b0;
            grant_mask <= '0;
        end else begin
            alu1_valid <= alu_first_v;
            alu2_valid <= alu_second_v;
            if (alu_first_v)  alu1_idx <= alu_first_idx;
            if (alu_second_v) alu2_idx <= alu_second_idx;
            if (mem_issue)    mem_idx  <= mem_first_idx;
            grant_mask <= grant_next;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    // Free-running counters; only reset clears them, flush does not
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_alu_issue <= '0;
            perf_mem_stall <= '0;
        end else begin
            perf_alu_issue <= perf_alu_issue + 32'(alu1_valid) + 32'(alu2_valid);
            if (mem_valid && !mem_ready) perf_mem_stall <= perf_mem_stall + 32'd1;
        end
    end
`else
    assign perf_alu_issue = '0;
    assign perf_mem_stall = '0;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed self-checking bench for rs_issue_scheduler.
module tb_rs_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] rs_ready;
    logic [31:0] rs_fu;
    logic [63:0] rs_rob;
    logic [3:0]  rob_head;
    logic        mem_ready;
    logic        alu1_valid, alu2_valid, mem_valid;
    logic [3:0]  alu1_idx, alu2_idx, mem_idx;
    logic [15:0] grant_mask;
    logic [2:0]  fu_rdy;
    logic [31:0] perf_alu_issue, perf_mem_stall;

    int passed = 0;
    int total  = 0;

    rs_issue_scheduler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .rs_ready(rs_ready), .rs_fu(rs_fu), .rs_rob(rs_rob),
        .rob_head(rob_head), .mem_ready(mem_ready),
        .alu1_valid(alu1_valid), .alu1_idx(alu1_idx),
        .alu2_valid(alu2_valid), .alu2_idx(alu2_idx),
        .mem_valid(mem_valid), .mem_idx(mem_idx),
        .grant_mask(grant_mask), .fu_rdy(fu_rdy),
        .perf_alu_issue(perf_alu_issue), .perf_mem_stall(perf_mem_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int i, input logic rdy, input logic [1:0] fu, input logic [3:0] rob);
        rs_ready[i]       = rdy;
        rs_fu[2*i +: 2]   = fu;
        rs_rob[4*i +: 4]  = rob;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0; rob_head = 4'd0;
        for (int i = 0; i < 16; i++) set_entry(i, 1'b1, 2'd0, 4'(i));
        tick(); tick();
        total++; if ({alu1_valid, alu2_valid, mem_valid} !== 3'b000) $display("FAIL reset_valids got=%b exp=000", {alu1_valid, alu2_valid, mem_valid}); else passed++;
        total++; if (fu_rdy !== 3'b111) $display("FAIL reset_fu_rdy got=%b exp=111", fu_rdy); else passed++;
        total++; if (grant_mask !== 16'h0000 || alu1_idx !== 4'd0) $display("FAIL reset_mask_idx got=%h/%0d exp=0000/0", grant_mask, alu1_idx); else passed++;
        total++; if (perf_alu_issue !== 32'd0 || perf_mem_stall !== 32'd0) $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_alu_issue, perf_mem_stall); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (!(alu1_valid === 1'b1 && alu1_idx === 4'd0 && alu2_valid === 1'b1 && alu2_idx === 4'd1))
            $display("FAIL reset_release_grant got=%b:%0d %b:%0d exp=1:0 1:1", alu1_valid, alu1_idx, alu2_valid, alu2_idx); else passed++;
        total++; if (grant_mask !== 16'h0003) $display("FAIL reset_release_mask got=%h exp=0003", grant_mask); else passed++;
        rs_ready = '0;
        tick();
        total++; if ({alu1_valid, alu2_valid} !== 2'b00) $display("FAIL reset_idle got=%b exp=00", {alu1_valid, alu2_valid}); else passed++;
    endtask

    task automatic test_alu_age();
        rob_head = 4'd14;
        set_entry(3, 1'b1, 2'd0, 4'd1);
        set_entry(5, 1'b1, 2'd0, 4'd15);
        set_entry(9, 1'b1, 2'd0, 4'd0);
        tick();
        total++; if (!(alu1_valid === 1'b1 && alu1_idx === 4'd5 && alu2_valid === 1'b1 && alu2_idx === 4'd9))
            $display("FAIL alu_age_pair got=%b:%0d %b:%0d exp=1:5 1:9", alu1_valid, alu1_idx, alu2_valid, alu2_idx); else passed++;
        total++; if (grant_mask !== 16'h0220) $display("FAIL alu_age_mask got=%h exp=0220", grant_mask); else passed++;
        rs_ready[5] = 1'b0; rs_ready[9] = 1'b0;
        tick();
        total++; if (!(alu1_valid === 1'b1 && alu1_idx === 4'd3 && alu2_valid === 1'b0 && alu2_idx === 4'd9))
            $display("FAIL alu_age_single got=%b:%0d %b:%0d exp=1:3 0:9", alu1_valid, alu1_idx, alu2_valid, alu2_idx); else passed++;
        total++; if (grant_mask !== 16'h0008) $display("FAIL alu_age_single_mask got=%h exp=0008", grant_mask); else passed++;
        rs_ready[3] = 1'b0;
        tick();
        total++; if (!(alu1_valid === 1'b0 && alu1_idx === 4'd3)) $display("FAIL alu_idx_hold got=%b:%0d exp=0:3", alu1_valid, alu1_idx); else passed++;
    endtask

    task automatic test_mem_handshake();
        rob_head = 4'd0;
        mem_ready = 1'b0;
        set_entry(2, 1'b1, 2'd1, 4'd3);
        tick();
        total++; if (!(mem_valid === 1'b1 && mem_idx === 4'd2 && fu_rdy === 3'b011))
            $display("FAIL mem_issue got=%b:%0d rdy=%b exp=1:2 rdy=011", mem_valid, mem_idx, fu_rdy); else passed++;
        total++; if (grant_mask !== 16'h0004) $display("FAIL mem_issue_mask got=%h exp=0004", grant_mask); else passed++;
        rs_ready[2] = 1'b0;
        set_entry(7, 1'b1, 2'd1, 4'd5);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (!(mem_valid === 1'b1 && mem_idx === 4'd2 && fu_rdy === 3'b011 && grant_mask === 16'h0000))
                $display("FAIL mem_hold_%0d got=%b:%0d rdy=%b mask=%h exp=1:2 rdy=011 mask=0000", k, mem_valid, mem_idx, fu_rdy, grant_mask); else passed++;
        end
        mem_ready = 1'b1;
        tick();
        total++; if (!(mem_valid === 1'b0 && fu_rdy === 3'b111 && grant_mask === 16'h0000))
            $display("FAIL mem_accept got=%b rdy=%b mask=%h exp=0 rdy=111 mask=0000", mem_valid, fu_rdy, grant_mask); else passed++;
        mem_ready = 1'b0;
        tick();
        total++; if (!(mem_valid === 1'b1 && mem_idx === 4'd7 && grant_mask === 16'h0080))
            $display("FAIL mem_second got=%b:%0d mask=%h exp=1:7 mask=0080", mem_valid, mem_idx, grant_mask); else passed++;
        rs_ready[7] = 1'b0;
        mem_ready = 1'b1;
        tick();
        total++; if (mem_valid !== 1'b0) $display("FAIL mem_second_accept got=%b exp=0", mem_valid); else passed++;
    endtask

    task automatic test_no_double_issue();
        mem_ready = 1'b0;
        set_entry(4, 1'b1, 2'd0, 4'd2);
        tick();
        total++; if (!(alu1_valid === 1'b1 && alu1_idx === 4'd4 && grant_mask === 16'h0010))
            $display("FAIL nodbl_first got=%b:%0d mask=%h exp=1:4 mask=0010", alu1_valid, alu1_idx, grant_mask); else passed++;
        tick();
        total++; if (!(alu1_valid === 1'b0 && alu2_valid === 1'b0 && grant_mask === 16'h0000))
            $display("FAIL nodbl_repeat got=%b%b mask=%h exp=00 mask=0000", alu1_valid, alu2_valid, grant_mask); else passed++;
        rs_ready[4] = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        set_entry(6, 1'b1, 2'd1, 4'd1);
        tick();
        total++; if (!(mem_valid === 1'b1 && mem_idx === 4'd6)) $display("FAIL flush_setup got=%b:%0d exp=1:6", mem_valid, mem_idx); else passed++;
        rs_ready[6] = 1'b0;
        set_entry(1, 1'b1, 2'd0, 4'd2);
        set_entry(8, 1'b1, 2'd1, 4'd3);
        flush = 1'b1; mem_ready = 1'b1;
        tick();
        total++; if (!(mem_valid === 1'b0 && alu1_valid === 1'b0 && alu2_valid === 1'b0 && grant_mask === 16'h0000 && fu_rdy === 3'b111))
            $display("FAIL flush_pend got=m%b a%b%b mask=%h rdy=%b exp=m0 a00 mask=0000 rdy=111", mem_valid, alu1_valid, alu2_valid, grant_mask, fu_rdy); else passed++;
        flush = 1'b0; mem_ready = 1'b0;
        tick();
        total++; if (!(alu1_valid === 1'b1 && alu1_idx === 4'd1 && mem_valid === 1'b1 && mem_idx === 4'd8))
            $display("FAIL flush_resume got=%b:%0d %b:%0d exp=1:1 1:8", alu1_valid, alu1_idx, mem_valid, mem_idx); else passed++;
        rs_ready = '0;
        mem_ready = 1'b1;
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_alu, exp_stall;
`ifdef ISSUE_PERF_CNT_EN
        exp_alu = 32'd20; exp_stall = 32'd4;
`else
        exp_alu = 32'd0;  exp_stall = 32'd0;
`endif
        rst_n = 1'b0; mem_ready = 1'b0; rob_head = 4'd0;
        rs_ready = '0;
        for (int i = 0; i < 16; i++) set_entry(i, 1'b0, 2'd0, 4'(i));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rs_ready = '0;
            rs_ready[(k % 4) * 2]     = 1'b1;
            rs_ready[(k % 4) * 2 + 1] = 1'b1;
            tick();
            total++; if (!(alu1_valid === 1'b1 && alu2_valid === 1'b1 && alu1_idx === 4'((k % 4) * 2)))
                $display("FAIL perf_pair_%0d got=%b%b idx=%0d exp=11 idx=%0d", k, alu1_valid, alu2_valid, alu1_idx, (k % 4) * 2); else passed++;
        end
        rs_ready = '0;
        set_entry(10, 1'b1, 2'd1, 4'd10);
        tick();
        rs_ready[10] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        total++; if (perf_alu_issue !== exp_alu) $display("FAIL perf_alu_issue got=%0d exp=%0d", perf_alu_issue, exp_alu); else passed++;
        total++; if (perf_mem_stall !== exp_stall) $display("FAIL perf_mem_stall got=%0d exp=%0d", perf_mem_stall, exp_stall); else passed++;
        mem_ready = 1'b1;
        tick();
    endtask

    initial begin
        rs_ready = '0; rs_fu = '0; rs_rob = '0;
        test_reset();
        test_alu_age();
        test_mem_handshake();
        test_no_double_issue();
        test_flush();
        test_perf();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
